i2s_rx_frontend: RTL and testbench

- Receives the serial I2S stream from the external audio codec and converts it into parallel 16-bit stereo samples with a one-cycle valid strobe.
- Sits directly upstream of the equalizer core and drives its lft_in, rht_in and valid inputs.
- Synchronizes the asynchronous codec clock, word-select and data into the system clock domain, tracks frame alignment, and recovers automatically from misaligned frames.

---
 rtl/eq_pkg.sv | 15 +
 rtl/i2s_rx_frontend_sync_edge.sv | 34 +++
 rtl/i2s_rx_frontend.sv | 149 ++++++++++++++
 tb/tb_i2s_rx_frontend.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/eq_pkg.sv
// Shared audio-path types and constants for the equalizer front end.
package eq_pkg;

  localparam int unsigned SMPL_BITS_DEF = 24;
  localparam int unsigned AUDIO_W       = 16;

  typedef logic signed [AUDIO_W-1:0] audio_t;

  typedef enum logic [1:0] {
    RESYNC,
    LEFT,
    RIGHT
  } i2s_state_t;

endpackage

// File: rtl/i2s_rx_frontend_sync_edge.sv
// Multi-flop synchronizer for one asynchronous input, with a 0->1 pulse
// derived from the synchronized level.
module sync_edge #(
  parameter int unsigned STAGES = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_in,
  output logic level,
  output logic rise_c
);

  logic [STAGES-1:0] sync_q, sync_d;
  logic              prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d_in};
    prev_d = sync_q[STAGES-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign level  = sync_q[STAGES-1];
  assign rise_c = sync_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/i2s_rx_frontend.sv
// I2S receiver: synchronizes the codec stream, tracks slot alignment and
// emits truncated stereo samples with a one-cycle valid strobe.
module i2s_rx_frontend
  import eq_pkg::*;
#(
  parameter int unsigned SMPL_BITS   = SMPL_BITS_DEF,
  parameter int unsigned OUT_BITS    = AUDIO_W,
  parameter int unsigned SYNC_STAGES = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       I2S_sclk,
  input  logic                       I2S_ws,
  input  logic                       I2S_data,
  output logic signed [OUT_BITS-1:0] lft_out,
  output logic signed [OUT_BITS-1:0] rht_out,
  output logic                       valid
);

  localparam int unsigned CNT_W = $clog2(SMPL_BITS + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(SMPL_BITS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SMPL_BITS - 1);

  logic sclk_lvl, sclk_rise_c;
  logic ws_s, ws_edge_unused_c;
  logic data_s, data_edge_unused_c;
  logic unused_sync;

  sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .d_in(I2S_sclk), .level(sclk_lvl), .rise_c(sclk_rise_c)
  );
  sync_edge #(.STAGES(SYNC_STAGES)) u_sync_ws (
    .clk(clk), .rst_n(rst_n), .d_in(I2S_ws), .level(ws_s), .rise_c(ws_edge_unused_c)
  );
  sync_edge #(.STAGES(SYNC_STAGES)) u_sync_data (
    .clk(clk), .rst_n(rst_n), .d_in(I2S_data), .level(data_s), .rise_c(data_edge_unused_c)
  );

  assign unused_sync = sclk_lvl ^ ws_edge_unused_c ^ data_edge_unused_c;

  i2s_state_t                  state_q, state_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic                        ws_prev_q, ws_prev_d;
  logic [SMPL_BITS-1:0]        lft_shift_q, lft_shift_d;
  logic [OUT_BITS-1:0]         lft_hold_q, lft_hold_d;
  logic [SMPL_BITS-2:0]        rht_shift_q, rht_shift_d;
  logic signed [OUT_BITS-1:0]  lft_out_q, lft_out_d;
  logic signed [OUT_BITS-1:0]  rht_out_q, rht_out_d;
  logic                        valid_q, valid_d;

  logic                        ws_fall_c, ws_rise_c, cnt_full_c;
  logic [SMPL_BITS-1:0]        rht_next_c;

  assign ws_fall_c  = ws_prev_q & ~ws_s;
  assign ws_rise_c  = ~ws_prev_q & ws_s;
  assign cnt_full_c = (cnt_q == CNT_FULL);
  // Right word including the bit arriving on this rise, so output needs no extra cycle
  assign rht_next_c = {rht_shift_q, data_s};

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ws_prev_d   = ws_prev_q;
    lft_shift_d = lft_shift_q;
    lft_hold_d  = lft_hold_q;
    rht_shift_d = rht_shift_q;
    lft_out_d   = lft_out_q;
    rht_out_d   = rht_out_q;
    valid_d     = 1'b0;

    if (sclk_rise_c) begin
      ws_prev_d = ws_s;
      unique case (state_q)
        RESYNC: begin
          if (ws_fall_c) begin
            state_d = LEFT;
            cnt_d   = '0;
          end
        end
        LEFT: begin
          if (ws_rise_c) begin
            if (cnt_full_c) begin
              state_d    = RIGHT;
              cnt_d      = '0;
              lft_hold_d = lft_shift_q[SMPL_BITS-1 -: OUT_BITS];
            end else begin
              state_d = RESYNC;
            end
          end else if (ws_fall_c) begin
            state_d = RESYNC;
          end else if (!cnt_full_c) begin
            lft_shift_d = {lft_shift_q[SMPL_BITS-2:0], data_s};
            cnt_d       = cnt_q + CNT_W'(1);
          end
        end
        RIGHT: begin
          if (ws_fall_c) begin
            if (cnt_full_c) begin
              state_d = LEFT;
              cnt_d   = '0;
            end else begin
              state_d = RESYNC;
            end
          end else if (ws_rise_c) begin
            state_d = RESYNC;
          end else if (!cnt_full_c) begin
            rht_shift_d = rht_next_c[SMPL_BITS-2:0];
            cnt_d       = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_LAST) begin
              valid_d   = 1'b1;
              lft_out_d = lft_hold_q;
              rht_out_d = rht_next_c[SMPL_BITS-1 -: OUT_BITS];
            end
          end
        end
        default: state_d = RESYNC;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RESYNC;
      cnt_q       <= '0;
      ws_prev_q   <= 1'b0;
      lft_shift_q <= '0;
      lft_hold_q  <= '0;
      rht_shift_q <= '0;
      lft_out_q   <= '0;
      rht_out_q   <= '0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ws_prev_q   <= ws_prev_d;
      lft_shift_q <= lft_shift_d;
      lft_hold_q  <= lft_hold_d;
      rht_shift_q <= rht_shift_d;
      lft_out_q   <= lft_out_d;
      rht_out_q   <= rht_out_d;
      valid_q     <= valid_d;
    end
  end

  assign lft_out = lft_out_q;
  assign rht_out = rht_out_q;
  assign valid   = valid_q;

endmodule

// File: tb/tb_i2s_rx_frontend.sv
// Directed bench for i2s_rx_frontend: drives I2S frames at clk/8 and checks
// captured samples, strobe counts, latency, reset and output hold.
module tb_i2s_rx_frontend;

  localparam int unsigned SYNC    = 3;
  localparam int unsigned HALF    = 40;                  // sclk half period = 4 clk periods
  localparam time         LAT_MAX = (SYNC + 2) * 10 + 5; // edge to valid, sampled on negedge

  logic               clk = 1'b0;
  logic               rst_n;
  logic               i2s_sclk, i2s_ws, i2s_data;
  logic signed [15:0] lft_out, rht_out;
  logic               valid;

  int   tests_run    = 0;
  int   tests_failed = 0;
  int   vcnt         = 0;
  int   hold_err     = 0;
  logic [15:0] last_l = '0, last_r = '0, prev_l = '0, prev_r = '0;
  time  last_valid_t = 0;
  time  t_cap        = 0;

  always #5 clk = ~clk;

  i2s_rx_frontend #(
    .SMPL_BITS(24), .OUT_BITS(16), .SYNC_STAGES(SYNC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .I2S_sclk(i2s_sclk), .I2S_ws(i2s_ws), .I2S_data(i2s_data),
    .lft_out(lft_out), .rht_out(rht_out), .valid(valid)
  );

  // Strobe recorder and hold watcher
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_l = lft_out;
      prev_r = rht_out;
    end else begin
      if (valid) begin
        vcnt++;
        last_valid_t = $time;
        last_l = lft_out;
        last_r = rht_out;
      end else if (lft_out !== prev_l || rht_out !== prev_r) begin
        hold_err++;
      end
      prev_l = lft_out;
      prev_r = rht_out;
    end
  end

  task automatic send_bit(input logic ws_v, input logic d_v);
    i2s_sclk = 1'b0;
    i2s_ws   = ws_v;
    i2s_data = d_v;
    #HALF;
    i2s_sclk = 1'b1;
    #HALF;
  endtask

  // Period 0 of a slot carries the previous slot's last bit; MSB follows.
  task automatic send_slot(input logic ws_v, input logic [23:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      logic b;
      if (i >= 1 && i <= 24) b = v[24-i];
      else                   b = 1'($urandom_range(0, 1));
      if (ws_v && i == 24) t_cap = $time + HALF;
      send_bit(ws_v, b);
    end
  endtask

  task automatic send_frame(input logic [23:0] l, input logic [23:0] r, input int n);
    send_slot(1'b0, l, n);
    send_slot(1'b1, r, n);
  endtask

  task automatic test_reset;
    rst_n    = 1'b0;
    i2s_sclk = 1'b0;
    i2s_ws   = 1'b1;
    i2s_data = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++;
    if (lft_out !== 16'sh0000) begin
      tests_failed++; $display("FAIL reset_lft: got %h expected 0000", lft_out);
    end
    tests_run++;
    if (rht_out !== 16'sh0000) begin
      tests_failed++; $display("FAIL reset_rht: got %h expected 0000", rht_out);
    end
    tests_run++;
    if (valid !== 1'b0) begin
      tests_failed++; $display("FAIL reset_valid: got %b expected 0", valid);
    end
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_nominal;
    int v0;
    send_slot(1'b1, 24'h0, 4);
    v0 = vcnt;
    send_frame(24'hABCDEF, 24'h123456, 25);
    repeat (10) @(negedge clk);
    tests_run++;
    if (vcnt - v0 != 1) begin
      tests_failed++; $display("FAIL nominal_count: got %0d strobes expected 1", vcnt - v0);
    end
    tests_run++;
    if (last_l !== 16'hABCD) begin
      tests_failed++; $display("FAIL nominal_lft: got %h expected abcd", last_l);
    end
    tests_run++;
    if (last_r !== 16'h1234) begin
      tests_failed++; $display("FAIL nominal_rht: got %h expected 1234", last_r);
    end
    tests_run++;
    if (!(last_valid_t > t_cap && last_valid_t - t_cap <= LAT_MAX)) begin
      tests_failed++;
      $display("FAIL nominal_latency: valid at %0t edge at %0t limit %0t", last_valid_t, t_cap, LAT_MAX);
    end
  endtask

  task automatic test_padded_32;
    for (int f = 0; f < 8; f++) begin
      int v0;
      v0 = vcnt;
      send_frame(24'h800000, 24'h7FFFFF, 32);
      repeat (10) @(negedge clk);
      tests_run++;
      if (vcnt - v0 != 1) begin
        tests_failed++; $display("FAIL padded_count[%0d]: got %0d expected 1", f, vcnt - v0);
      end
      tests_run++;
      if (last_l !== 16'h8000) begin
        tests_failed++; $display("FAIL padded_lft[%0d]: got %h expected 8000", f, last_l);
      end
      tests_run++;
      if (last_r !== 16'h7FFF) begin
        tests_failed++; $display("FAIL padded_rht[%0d]: got %h expected 7fff", f, last_r);
      end
    end
  endtask

  task automatic test_short_slot;
    int v0;
    v0 = vcnt;
    send_slot(1'b0, 24'hFFFFFF, 21);
    send_slot(1'b1, 24'h555555, 32);
    repeat (10) @(negedge clk);
    tests_run++;
    if (vcnt - v0 != 0) begin
      tests_failed++; $display("FAIL short_count: got %0d strobes expected 0", vcnt - v0);
    end
    v0 = vcnt;
    send_frame(24'h000100, 24'hFFFF00, 32);
    repeat (10) @(negedge clk);
    tests_run++;
    if (vcnt - v0 != 1) begin
      tests_failed++; $display("FAIL short_recover_count: got %0d expected 1", vcnt - v0);
    end
    tests_run++;
    if (last_l !== 16'h0001) begin
      tests_failed++; $display("FAIL short_recover_lft: got %h expected 0001", last_l);
    end
    tests_run++;
    if (last_r !== 16'hFFFF) begin
      tests_failed++; $display("FAIL short_recover_rht: got %h expected ffff", last_r);
    end
  endtask

  task automatic test_reset_mid;
    int v0;
    v0 = vcnt;
    fork
      send_frame(24'h5A5A5A, 24'hA5A5A5, 32);
      begin
        repeat (150) @(negedge clk);
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (lft_out !== 16'sh0000) begin
          tests_failed++; $display("FAIL midreset_lft: got %h expected 0000", lft_out);
        end
        tests_run++;
        if (rht_out !== 16'sh0000) begin
          tests_failed++; $display("FAIL midreset_rht: got %h expected 0000", rht_out);
        end
        tests_run++;
        if (valid !== 1'b0) begin
          tests_failed++; $display("FAIL midreset_valid: got %b expected 0", valid);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
      end
    join
    repeat (10) @(negedge clk);
    tests_run++;
    if (vcnt - v0 != 0) begin
      tests_failed++; $display("FAIL midreset_count: got %0d strobes expected 0", vcnt - v0);
    end
    v0 = vcnt;
    send_frame(24'h400000, 24'hC00000, 32);
    repeat (10) @(negedge clk);
    tests_run++;
    if (vcnt - v0 != 1) begin
      tests_failed++; $display("FAIL postreset_count: got %0d expected 1", vcnt - v0);
    end
    tests_run++;
    if (last_l !== 16'h4000 || last_r !== 16'hC000) begin
      tests_failed++; $display("FAIL postreset_data: got %h/%h expected 4000/c000", last_l, last_r);
    end
  endtask

  task automatic test_timing_phase;
    for (int k = 0; k < 6; k++) begin
      int v0;
      logic [23:0] l, r;
      #($urandom_range(1, 9));
      if ($time % 10 == 5) #1;
      l  = 24'($urandom);
      r  = 24'($urandom);
      v0 = vcnt;
      send_frame(l, r, 32);
      repeat (10) @(negedge clk);
      tests_run++;
      if (vcnt - v0 != 1) begin
        tests_failed++; $display("FAIL phase_count[%0d]: got %0d expected 1", k, vcnt - v0);
      end
      tests_run++;
      if (last_l !== l[23:8]) begin
        tests_failed++; $display("FAIL phase_lft[%0d]: got %h expected %h", k, last_l, l[23:8]);
      end
      tests_run++;
      if (last_r !== r[23:8]) begin
        tests_failed++; $display("FAIL phase_rht[%0d]: got %h expected %h", k, last_r, r[23:8]);
      end
      tests_run++;
      if (!(last_valid_t > t_cap && last_valid_t - t_cap <= LAT_MAX)) begin
        tests_failed++;
        $display("FAIL phase_latency[%0d]: valid at %0t edge at %0t limit %0t", k, last_valid_t, t_cap, LAT_MAX);
      end
    end
  endtask

  task automatic test_hold;
    tests_run++;
    if (hold_err != 0) begin
      tests_failed++; $display("FAIL hold: got %0d output changes outside valid expected 0", hold_err);
    end
    tests_run++;
    if (lft_out !== last_l || rht_out !== last_r) begin
      tests_failed++;
      $display("FAIL hold_final: got %h/%h expected %h/%h", lft_out, rht_out, last_l, last_r);
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_padded_32();
    test_short_slot();
    test_reset_mid();
    test_timing_phase();
    test_hold();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
